// File: rtl/csr_trap_ctrl.sv
// ---------------------------------------------------------------------------
// csr_trap_ctrl
//
// Purpose:
//   Sequencing controller and storage for the machine-mode CSR set
//   (mstatus, mtvec, mepc, mcause and optionally mscratch). It accepts one
//   CSR or trap operation at a time from the execute stage and runs it as
//   read -> commit -> respond. It returns the old CSR value for rd
//   write-back, and a PC redirect for ECALL/MRET.
//
// Handshake (both ports):
//   A transfer happens on a rising edge where valid and ready are both high.
//   The producer holds its payload stable while valid is high. The
//   controller samples in_* only on the accept edge. It holds every out_*
//   stable from the edge that raises out_valid until the edge that
//   completes the out_valid & out_ready transfer.
//
// Configuration:
//   CSR_MSCRATCH_EN  when defined, mscratch (0x340) is implemented.
//                    Otherwise any access to 0x340 is illegal.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   in_valid        request present
//   in_ready        controller idle and out of reset
//   in_op           0 CSRRW, 1 CSRRS, 2 CSRRC, 3 ECALL, 4 MRET, 5-7 illegal
//   in_csr_addr     CSR address; ignored for ECALL/MRET
//   in_src          rs1 value or zero-extended zimm
//   in_src_zero     rs1/zimm field is zero; suppresses CSRRS/CSRRC writes
//   in_pc           PC of the request
//   out_valid       response present
//   out_ready       consumer takes the response
//   out_rdata       old CSR value; 0 for ECALL, MRET and illegal requests
//   out_redirect    fetch must jump to out_target
//   out_target      redirect PC
//   out_illegal     request was illegal; no state was changed
// ---------------------------------------------------------------------------
module csr_trap_ctrl #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MSTATUS_RST = XLEN'(32'h1800)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [11:0]     in_csr_addr,
    input  logic [XLEN-1:0] in_src,
    input  logic            in_src_zero,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rdata,
    output logic            out_redirect,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [2:0] OP_CSRRW = 3'd0;
    localparam logic [2:0] OP_CSRRS = 3'd1;
    localparam logic [2:0] OP_CSRRC = 3'd2;
    localparam logic [2:0] OP_ECALL = 3'd3;
    localparam logic [2:0] OP_MRET  = 3'd4;

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;

    // MPP[12:11] is hard-wired to machine mode.
    localparam logic [XLEN-1:0] MPP_MASK   = XLEN'(32'h1800);
    // Low two bits of mtvec/mepc always read zero.
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(32'h3);
    localparam logic [XLEN-1:0] CAUSE_ECALL_M = XLEN'(32'd11);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Latched request
    // ------------------------------------------------------------------
    logic [2:0]      req_op;
    logic [11:0]     req_addr;
    logic [XLEN-1:0] req_src;
    logic            req_src_zero;
    logic [XLEN-1:0] req_pc;

    // ------------------------------------------------------------------
    // CSR storage
    // ------------------------------------------------------------------
    logic [XLEN-1:0] mstatus;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
`ifdef CSR_MSCRATCH_EN
    logic [XLEN-1:0] mscratch;
`endif

    // ------------------------------------------------------------------
    // Decode of the latched request (used only in EXEC)
    // ------------------------------------------------------------------
    logic            sel_mstatus;
    logic            sel_mtvec;
    logic            sel_mepc;
    logic            sel_mcause;
    logic            sel_mscratch;
    logic            addr_hit;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic            is_csr_op;
    logic            is_ecall;
    logic            is_mret;
    logic            req_illegal;
    logic            do_write;
    logic            write_en;

    always_comb begin
        sel_mstatus  = 1'b0;
        sel_mtvec    = 1'b0;
        sel_mepc     = 1'b0;
        sel_mcause   = 1'b0;
        sel_mscratch = 1'b0;
        old_val      = '0;
        case (req_addr)
            ADDR_MSTATUS: begin
                sel_mstatus = 1'b1;
                old_val     = mstatus;
            end
            ADDR_MTVEC: begin
                sel_mtvec = 1'b1;
                old_val   = mtvec;
            end
            ADDR_MEPC: begin
                sel_mepc = 1'b1;
                old_val  = mepc;
            end
            ADDR_MCAUSE: begin
                sel_mcause = 1'b1;
                old_val    = mcause;
            end
`ifdef CSR_MSCRATCH_EN
            ADDR_MSCRATCH: begin
                sel_mscratch = 1'b1;
                old_val      = mscratch;
            end
`endif
            default: ;
        endcase
        addr_hit = sel_mstatus | sel_mtvec | sel_mepc | sel_mcause | sel_mscratch;

        is_csr_op = (req_op == OP_CSRRW) || (req_op == OP_CSRRS) || (req_op == OP_CSRRC);
        is_ecall  = (req_op == OP_ECALL);
        is_mret   = (req_op == OP_MRET);

        // Trap ops ignore the address. CSR ops must hit a mapped register.
        req_illegal = !((is_csr_op && addr_hit) || is_ecall || is_mret);

        new_val  = req_src;
        write_en = 1'b0;
        case (req_op)
            OP_CSRRW: begin
                new_val  = req_src;
                write_en = 1'b1;
            end
            OP_CSRRS: begin
                new_val  = old_val | req_src;
                write_en = !req_src_zero;
            end
            OP_CSRRC: begin
                new_val  = old_val & ~req_src;
                write_en = !req_src_zero;
            end
            default: ;
        endcase
        do_write = is_csr_op && addr_hit && write_en;
    end

    // Ready only when idle, and never while reset is asserted.
    assign in_ready = (state == S_IDLE) && !rst;

    // ------------------------------------------------------------------
    // FSM, CSR commit and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            req_op       <= '0;
            req_addr     <= '0;
            req_src      <= '0;
            req_src_zero <= 1'b0;
            req_pc       <= '0;
            mstatus      <= MSTATUS_RST;
            mtvec        <= '0;
            mepc         <= '0;
            mcause       <= '0;
`ifdef CSR_MSCRATCH_EN
            mscratch     <= '0;
`endif
            out_valid    <= 1'b0;
            out_rdata    <= '0;
            out_redirect <= 1'b0;
            out_target   <= '0;
            out_illegal  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        req_op       <= in_op;
                        req_addr     <= in_csr_addr;
                        req_src      <= in_src;
                        req_src_zero <= in_src_zero;
                        req_pc       <= in_pc;
                        state        <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    out_valid <= 1'b1;
                    state     <= S_RESP;
                    if (req_illegal) begin
                        out_rdata    <= '0;
                        out_redirect <= 1'b0;
                        out_target   <= '0;
                        out_illegal  <= 1'b1;
                    end else if (is_ecall) begin
                        mepc    <= req_pc & ALIGN_MASK;
                        mcause  <= CAUSE_ECALL_M;
                        // Save MIE into MPIE and disable interrupts.
                        mstatus <= ((mstatus & ~(XLEN'(1) << MPIE_BIT) & ~(XLEN'(1) << MIE_BIT))
                                    | (XLEN'(mstatus[MIE_BIT]) << MPIE_BIT)) | MPP_MASK;
                        out_rdata    <= '0;
                        out_redirect <= 1'b1;
                        out_target   <= mtvec;
                        out_illegal  <= 1'b0;
                    end else if (is_mret) begin
                        // Restore MIE from MPIE and set MPIE.
                        mstatus <= ((mstatus & ~(XLEN'(1) << MIE_BIT))
                                    | (XLEN'(mstatus[MPIE_BIT]) << MIE_BIT)
                                    | (XLEN'(1) << MPIE_BIT)) | MPP_MASK;
                        out_rdata    <= '0;
                        out_redirect <= 1'b1;
                        out_target   <= mepc;
                        out_illegal  <= 1'b0;
                    end else begin
                        if (do_write) begin
                            if (sel_mstatus) mstatus <= new_val | MPP_MASK;
                            if (sel_mtvec)   mtvec   <= new_val & ALIGN_MASK;
                            if (sel_mepc)    mepc    <= new_val & ALIGN_MASK;
                            if (sel_mcause)  mcause  <= new_val;
`ifdef CSR_MSCRATCH_EN
                            if (sel_mscratch) mscratch <= new_val;
`endif
                        end
                        out_rdata    <= old_val;
                        out_redirect <= 1'b0;
                        out_target   <= '0;
                        out_illegal  <= 1'b0;
                    end
                end

                S_RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
